// File: rtl/pingpong_sweep_scheduler_if.sv
// Control/response bundle between the sweep scheduler and the 16:1 take-block mux.
interface pingpong_sweep_scheduler_if #(
  parameter int SFT_BIT = 4
);
  logic [SFT_BIT-1:0] sel;
  logic               needPang;
  logic               myTurnPingPong;
  logic [SFT_BIT-1:0] needPangStartInc;
  logic [SFT_BIT-1:0] needPangEndInc;
  logic               takeBlko;

  // scheduler side: owns the mux controls, listens to the take response
  modport master (
    output sel, needPang, myTurnPingPong, needPangStartInc, needPangEndInc,
    input  takeBlko
  );

  // mux side
  modport slave (
    input  sel, needPang, myTurnPingPong, needPangStartInc, needPangEndInc,
    output takeBlko
  );
endinterface

// File: rtl/pingpong_sweep_scheduler.sv
// Round-robin ping/pang arbiter that runs one full sel sweep on the 16:1
// pipelined take-block mux, drains its pipeline and reports the take count.
module pingpong_sweep_scheduler #(
  parameter int SFT_BIT  = 4,
  parameter int NUM_SUB  = 16,
  parameter int PIPE_LAT = 4,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ping_req,
  input  logic [SFT_BIT-1:0] ping_start,
  input  logic [SFT_BIT-1:0] ping_end,
  input  logic               ping_force,
  input  logic               pang_req,
  input  logic [SFT_BIT-1:0] pang_start,
  input  logic [SFT_BIT-1:0] pang_end,
  input  logic               pang_force,
  output logic               ping_gnt,
  output logic               pang_gnt,
  output logic               busy,
  output logic               done,
  output logic               done_owner,
  output logic [CNT_W-1:0]   take_cnt,
  pingpong_sweep_scheduler_if.master mux
);

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t              state;
  logic                last_owner;   // 1 = ping had the previous sweep
  logic [PIPE_LAT-1:0] vld_pipe;     // tags which takeBlko samples belong to the sweep
  logic [DW-1:0]       drain_cnt;
  logic [CNT_W-1:0]    take_acc;

  logic             pick_ping;
  logic             take_inc;
  logic [CNT_W-1:0] take_next;

  // ping wins when alone, or on a tie when pang owned the last sweep
  assign pick_ping = ping_req & (~pang_req | ~last_owner);
  // a take only counts when its matching sel came from this sweep
  assign take_inc  = vld_pipe[PIPE_LAT-1] & mux.takeBlko;
  assign take_next = take_acc + CNT_W'(take_inc);

  // sweep FSM, tag pipeline and take counter; all outputs registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state                <= IDLE;
      last_owner           <= 1'b0;
      vld_pipe             <= '0;
      drain_cnt            <= '0;
      take_acc             <= '0;
      ping_gnt             <= 1'b0;
      pang_gnt             <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      done_owner           <= 1'b0;
      take_cnt             <= '0;
      mux.sel              <= '0;
      mux.needPang         <= 1'b0;
      mux.myTurnPingPong   <= 1'b0;
      mux.needPangStartInc <= '0;
      mux.needPangEndInc   <= '0;
    end else begin
      ping_gnt <= 1'b0;
      pang_gnt <= 1'b0;
      done     <= 1'b0;
      vld_pipe <= (vld_pipe << 1) | PIPE_LAT'(state == SWEEP);
      take_acc <= take_next;

      case (state)
        IDLE: begin
          mux.sel <= '0;
          if (ping_req || pang_req) begin
            state                <= SWEEP;
            busy                 <= 1'b1;
            ping_gnt             <= pick_ping;
            pang_gnt             <= ~pick_ping;
            last_owner           <= pick_ping;
            take_acc             <= '0;
            mux.myTurnPingPong   <= pick_ping;
            mux.needPangStartInc <= pick_ping ? ping_start : pang_start;
            mux.needPangEndInc   <= pick_ping ? ping_end   : pang_end;
            mux.needPang         <= pick_ping ? ping_force : pang_force;
          end
        end
        SWEEP: begin
          if (mux.sel == SFT_BIT'(NUM_SUB - 1)) begin
            state     <= DRAIN;
            mux.sel   <= '0;
            drain_cnt <= '0;
          end else begin
            mux.sel <= mux.sel + 1'b1;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          // last drain cycle also sees the final tagged take, so use take_next
          if (drain_cnt == DW'(PIPE_LAT - 1)) begin
            state      <= DONE;
            done       <= 1'b1;
            done_owner <= mux.myTurnPingPong;
            take_cnt   <= take_next;
            busy       <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pingpong_sweep_scheduler.sv
// Directed bench: drives ping/pang requests, models the mux window + latency,
// and checks grants, sel timeline, completion and take counts.
module tb_pingpong_sweep_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       ping_req, pang_req;
  logic [3:0] ping_start, ping_end, pang_start, pang_end;
  logic       ping_force, pang_force;
  logic       ping_gnt, pang_gnt, busy, done, done_owner;
  logic [4:0] take_cnt;
  logic       force_take = 1'b0;
  logic [3:0] mdl = '0;
  logic       take_now;
  int         total = 0;
  int         bad = 0;
  int         seen_done;

  pingpong_sweep_scheduler_if #(.SFT_BIT(4)) bus ();

  pingpong_sweep_scheduler #(.SFT_BIT(4), .NUM_SUB(16), .PIPE_LAT(4), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .ping_req(ping_req), .ping_start(ping_start), .ping_end(ping_end), .ping_force(ping_force),
    .pang_req(pang_req), .pang_start(pang_start), .pang_end(pang_end), .pang_force(pang_force),
    .ping_gnt(ping_gnt), .pang_gnt(pang_gnt), .busy(busy),
    .done(done), .done_owner(done_owner), .take_cnt(take_cnt),
    .mux(bus.master)
  );

  always #5 clk = ~clk;

  // mux behaviour: take decision on the current sel, returned PIPE_LAT cycles later
  assign take_now = bus.myTurnPingPong &&
                    ((bus.sel < bus.needPangStartInc) || (bus.sel > bus.needPangEndInc) || bus.needPang);
  always @(posedge clk) mdl <= {mdl[2:0], take_now};
  assign bus.takeBlko = force_take | mdl[3];

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one complete sweep from IDLE; jitter scrambles ping config after grant
  task automatic sweep(input logic p, input logic [3:0] s, input logic [3:0] e,
                       input logic f, input int exp_cnt, input bit jitter);
    if (p) begin
      ping_req = 1; ping_start = s; ping_end = e; ping_force = f;
    end else begin
      pang_req = 1; pang_start = s; pang_end = e; pang_force = f;
    end
    step();
    chk("gnt_ping", ping_gnt, p);
    chk("gnt_pang", pang_gnt, !p);
    chk("sel0", bus.sel, 0);
    chk("busy_sweep", busy, 1);
    chk("turn", bus.myTurnPingPong, p);
    chk("win_start", bus.needPangStartInc, s);
    chk("win_end", bus.needPangEndInc, e);
    chk("win_force", bus.needPang, f);
    ping_req = 0; pang_req = 0;
    for (int i = 1; i < 16; i++) begin
      if (jitter) begin
        ping_start = 4'($urandom); ping_end = 4'($urandom); ping_force = 1'($urandom);
      end
      step();
      chk("sel_inc", bus.sel, i);
      chk("gnt_low", ping_gnt | pang_gnt, 0);
      if (jitter) begin
        chk("held_start", bus.needPangStartInc, s);
        chk("held_end", bus.needPangEndInc, e);
        chk("held_force", bus.needPang, f);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_nodone", done, 0);
      chk("drain_busy", busy, 1);
    end
    step();
    chk("done", done, 1);
    chk("done_owner", done_owner, p);
    chk("take_cnt", take_cnt, exp_cnt);
    chk("busy_done", busy, 0);
    step();
    chk("done_pulse", done, 0);
    chk("cnt_hold", take_cnt, exp_cnt);
  endtask

  initial begin
    reset = 0;
    ping_req = 1; pang_req = 1;
    ping_start = 4'd4; ping_end = 4'd7; ping_force = 0;
    pang_start = 4'd2; pang_end = 4'd5; pang_force = 1;
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", ping_gnt | pang_gnt, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", take_cnt, 0);

    // both requesting continuously: ping, pang, ping, 22 cycles apart
    reset = 1;
    step();                                   // cycle 1
    chk("alt_ping1", ping_gnt, 1);
    chk("alt_pang1_lo", pang_gnt, 0);
    step(20);                                 // cycle 21
    chk("alt_done1", done, 1);
    chk("alt_own1", done_owner, 1);
    chk("alt_cnt1", take_cnt, 12);
    chk("alt_gnt_vs_done", ping_gnt | pang_gnt, 0);
    step();                                   // cycle 22
    chk("alt_gap", ping_gnt | pang_gnt, 0);
    step();                                   // cycle 23
    chk("alt_pang", pang_gnt, 1);
    chk("alt_ping_lo", ping_gnt, 0);
    chk("alt_pang_turn", bus.myTurnPingPong, 0);
    step(20);                                 // cycle 43
    chk("alt_done2", done, 1);
    chk("alt_own2", done_owner, 0);
    chk("alt_cnt2", take_cnt, 0);
    step(2);                                  // cycle 45
    chk("alt_ping2", ping_gnt, 1);
    chk("alt_pang2_lo", pang_gnt, 0);
    ping_req = 0; pang_req = 0;
    step(20);                                 // cycle 65
    chk("alt_done3", done, 1);
    chk("alt_cnt3", take_cnt, 12);
    step();

    // window variants
    sweep(1, 4'd4, 4'd7, 0, 12, 0);
    sweep(1, 4'd9, 4'd3, 0, 16, 0);
    sweep(1, 4'd0, 4'd15, 1, 16, 0);
    sweep(1, 4'd0, 4'd15, 0, 0, 0);
    sweep(0, 4'd9, 4'd3, 1, 0, 0);

    // config latched at grant while ping inputs jitter
    sweep(1, 4'd2, 4'd12, 0, 5, 1);

    // takeBlko stuck high: only the 16 tagged samples count
    force_take = 1;
    step(5);
    sweep(1, 4'd0, 4'd15, 0, 16, 0);
    force_take = 0;

    // reset mid-sweep at sel=7 aborts without completion
    ping_req = 1; ping_start = 4'd4; ping_end = 4'd7; ping_force = 0;
    step();
    ping_req = 0;
    step(7);
    chk("mid_sel7", bus.sel, 7);
    reset = 0;
    step();
    reset = 1;
    chk("mid_busy", busy, 0);
    chk("mid_sel", bus.sel, 0);
    chk("mid_turn", bus.myTurnPingPong, 0);
    chk("mid_start", bus.needPangStartInc, 0);
    chk("mid_end", bus.needPangEndInc, 0);
    chk("mid_force", bus.needPang, 0);
    chk("mid_cnt", take_cnt, 0);
    chk("mid_done", done, 0);
    seen_done = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (done) seen_done++;
    end
    chk("mid_no_done", seen_done, 0);
    chk("mid_idle", busy, 0);
    sweep(1, 4'd4, 4'd7, 0, 12, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pingpong_sweep_scheduler.md
Name: pingpong_sweep_scheduler

Overview:
- Arbitrates the 16:1 pipelined take-block mux between two requesters, ping and pang.
- Sequences a full sel sweep (0..NUM_SUB-1, one per cycle) for the granted side.
- Drives the mux window and turn controls, then counts the mux's delayed takeBlko responses.
- Reports one completion per sweep. Sits directly upstream of the mux and owns its sel/needPang/myTurnPingPong/window inputs.

Parameters:
- SFT_BIT, 4, width of sel and window bounds
- NUM_SUB, 16, sub-blocks per sweep (must equal 2**SFT_BIT)
- PIPE_LAT, 4, cycles from sel presented to matching takeBlko from the mux
- CNT_W, 5, take counter width ($clog2(NUM_SUB+1))

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (sampled on clk; 0 = reset)
- ping_req  in  1  ping requests a sweep (level)
- ping_start  in  SFT_BIT  ping hold-window start, inclusive
- ping_end  in  SFT_BIT  ping hold-window end, inclusive
- ping_force  in  1  ping forces take of every sub-block
- pang_req / pang_start / pang_end / pang_force  as ping, for pang
- ping_gnt  out  1  one-cycle grant pulse to ping
- pang_gnt  out  1  one-cycle grant pulse to pang
- busy  out  1  sweep or drain in progress
- sel  out  SFT_BIT  to mux sel
- needPang  out  1  to mux needPang
- myTurnPingPong  out  1  to mux; 1 = ping owns sweep
- needPangStartInc  out  SFT_BIT  to mux window start
- needPangEndInc  out  SFT_BIT  to mux window end
- takeBlko  in  1  from mux, PIPE_LAT cycles after its sel
- done  out  1  one-cycle completion pulse
- done_owner  out  1  1 = ping's sweep, 0 = pang's; valid with done
- take_cnt  out  CNT_W  takeBlko count for the completed sweep; valid with done, held until next done

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; all outputs 0; last_owner=pang, so ping wins the first tie; valid-tag shift register cleared; internal counters 0. Reset mid-sweep or mid-drain aborts without a done pulse.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE, no req: outputs hold; sel=0.
- IDLE, any req at edge t:
  - Round-robin pick: if both requesters are active, grant the one != last_owner.
  - At t+1: grant pulse high, state SWEEP, busy=1, sel=0.
  - Latch the winner's start/end/force into needPangStartInc/needPangEndInc/needPang.
  - myTurnPingPong = (winner==ping); last_owner updated.
  - Config is held constant through SWEEP and DRAIN; requester inputs are ignored after the grant.
- SWEEP: sel increments by 1 each cycle, 0..NUM_SUB-1. A valid tag of 1 enters a PIPE_LAT-deep shift register each SWEEP cycle. After sel=NUM_SUB-1, go to DRAIN; sel returns to 0.
- DRAIN: exactly PIPE_LAT cycles; tag 0 enters. Then go to DONE.
- Counting: take_acc increments when the tag at shift-register output==1 and takeBlko==1. Samples outside tagged cycles are ignored. take_acc clears on grant.
- DONE: a single cycle.
  - done=1, done_owner=winner, take_cnt=take_acc (0..NUM_SUB, no overflow), busy=0.
  - Next state IDLE. A request pending in DONE is arbitrated in the following IDLE cycle.
  - Minimum grant-to-grant spacing is NUM_SUB+PIPE_LAT+2 cycles.
- Window semantics (enforced by the mux, assumed for checking):
  - A sub-block is taken iff (sel<start || sel>end || force) && myTurnPingPong.
  - start>end gives an empty hold window, so all sub-blocks are taken.
  - Pang sweeps therefore always count 0; this is expected, not an error.
- Timeline for a request seen at edge 0: grant and sel=0 at cycle 1; sel=15 at cycle 16; DRAIN cycles 17..20; done at cycle 21.
- Grant pulses are never simultaneous. done and a grant never coincide.

Test Plan:
- Ping only, start=4, end=7, force=0, mux model attached -> ping_gnt at cycle 1, sel 0..15 over cycles 1..16, done at cycle 21, done_owner=1, take_cnt=12.
- Ping, start=9, end=3 (inverted), force=0 -> take_cnt=16. Ping, start=0, end=15, force=1 -> take_cnt=16. Ping, start=0, end=15, force=0 -> take_cnt=0.
- Ping and pang requesting continuously from reset release -> grants alternate ping, pang, ping; grant-to-grant spacing 22 cycles; pang completions report done_owner=0, take_cnt=0.
- Change ping_start/ping_end/ping_force every cycle after the grant -> needPangStartInc/needPangEndInc/needPang stay at the values latched at grant; take_cnt matches the latched window.
- Drive takeBlko=1 constantly, including during IDLE and the first PIPE_LAT SWEEP cycles -> take_cnt=16 exactly, with no counts from untagged cycles.
- Assert reset=0 for 1 cycle at sel=7 -> next cycle all outputs 0, state IDLE, no done pulse. The next ping_req gives a clean sweep with correct take_cnt.
